// File: rtl/ext_pkg.sv
// ext_pkg: shared extension-mode and requester-index constants for the extension unit.
package ext_pkg;
   localparam logic [1:0] EXT_ZEXT   = 2'b00;
   localparam logic [1:0] EXT_SEXT16 = 2'b01;
   localparam logic [1:0] EXT_SEXT8  = 2'b10;
   localparam logic [1:0] EXT_LUI    = 2'b11;
   localparam int REQ_DEC = 0;
   localparam int REQ_LSU = 1;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extension (zext, sext16, sext8, upper-immediate shift).
module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  data,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] result
);
   logic [OUT_W-1:0] zext, sext16, sext8, lui;
   assign zext   = OUT_W'(data);
   assign sext16 = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
   assign sext8  = {{(OUT_W-8){data[7]}}, data[7:0]};
   assign lui    = zext << IN_W;
   assign result = (mode == EXT_LUI)    ? lui    :
                   (mode == EXT_SEXT8)  ? sext8  :
                   (mode == EXT_SEXT16) ? sext16 : zext;
endmodule

// File: rtl/ext_unit_arbiter.sv
// ext_unit_arbiter: round-robin sharing of one ext_core between decode and LSU,
// with a single registered valid/ready output stage.
module ext_unit_arbiter
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [IN_W-1:0]  req0_data,
   input  logic [1:0]       req0_mode,
   input  logic [IN_W-1:0]  req1_data,
   input  logic [1:0]       req1_mode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [OUT_W-1:0] res_data,
   output logic             res_id
);
   if (OUT_W < 2*IN_W) begin : g_bad_cfg
      $error("ext_unit_arbiter: OUT_W must be at least 2*IN_W");
   end
   logic             rr_last;
   logic             out_free;
   logic [1:0]       grant;
   logic             sel;
   logic             accept;
   logic [OUT_W-1:0] ext_result;
   assign out_free  = ~res_valid | res_ready;
   // On a tie the requester that did not win last time gets the grant.
   assign grant     = (req_valid == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : req_valid;
   assign req_ready = grant & {2{out_free & rst_n}};
   assign accept    = |(req_valid & req_ready);
   assign sel       = req_ready[REQ_LSU];
   ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .data   (sel ? req1_data : req0_data),
      .mode   (sel ? req1_mode : req0_mode),
      .result (ext_result)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= 1'b0;
         rr_last   <= 1'b1;
      end else if (accept) begin
         res_valid <= 1'b1;
         res_data  <= ext_result;
         res_id    <= sel;
         rr_last   <= sel;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ext_unit_arbiter.sv
// tb_ext_unit_arbiter: directed and random checks of ext_unit_arbiter against a
// transaction-level reference model.
module tb_ext_unit_arbiter;
   import ext_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready;
   logic [15:0] req0_data, req1_data;
   logic [1:0]  req0_mode, req1_mode;
   logic        res_valid, res_ready, res_id;
   logic [31:0] res_data;
   int vectors = 0, miscompares = 0;
   int m_last;
   logic m_valid, m_id;
   logic [31:0] m_data;
   logic [31:0] held_data;
   logic held_id;

   ext_unit_arbiter #(.IN_W(16), .OUT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req0_data(req0_data), .req0_mode(req0_mode), .req1_data(req1_data), .req1_mode(req1_mode),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
      logic [7:0] b;
      b = d[7:0];
      case (m)
         EXT_ZEXT:   return 32'(d);
         EXT_SEXT16: return 32'($signed(d));
         EXT_SEXT8:  return 32'($signed(b));
         default:    return 32'(d) * 32'd65536;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 32'h0;
      m_id    = 1'b0;
      m_last  = 1;
   endtask

   // One clock of stimulus: checks ready before the edge and the result after it.
   task automatic step(input logic [1:0] v, input logic [15:0] d0, input logic [1:0] m0,
                       input logic [15:0] d1, input logic [1:0] m1, input logic rdy);
      int w;
      logic free;
      logic [1:0] er;
      @(negedge clk);
      req_valid = v; req0_data = d0; req0_mode = m0;
      req1_data = d1; req1_mode = m1; res_ready = rdy;
      #1;
      free = !m_valid || rdy;
      w = (v == 2'b11) ? 1 - m_last : v[0] ? 0 : v[1] ? 1 : -1;
      er = (free && w >= 0) ? 2'(1 << w) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(er));
      @(posedge clk);
      #1;
      if (er != 2'b00) begin
         m_valid = 1'b1;
         m_data  = (w == 0) ? ref_ext(d0, m0) : ref_ext(d1, m1);
         m_id    = (w == 1);
         m_last  = w;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("res_data", res_data, m_data);
      chk("res_id", 32'(res_id), 32'(m_id));
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      req_valid = 2'b00;
      #1;
      model_reset();
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_data", res_data, 32'h0);
      chk("rst_id", 32'(res_id), 32'd0);
      req_valid = 2'b11;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 2'b00;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; req0_data = '0; req0_mode = '0;
      req1_data = '0; req1_mode = '0; res_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", 32'(res_valid), 32'd0);
      chk("init_data", res_data, 32'h0);
      chk("init_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step(2'b01, 16'h0005, EXT_SEXT16, 16'h0, EXT_ZEXT, 1'b1);
      chk("tp_first", res_data, 32'h00000005);

      step(2'b10, 16'h0, EXT_ZEXT, 16'hFFFA, EXT_SEXT16, 1'b1);
      chk("tp_sext16", res_data, 32'hFFFFFFFA);
      step(2'b10, 16'h0, EXT_ZEXT, 16'h8000, EXT_ZEXT, 1'b1);
      chk("tp_zext", res_data, 32'h00008000);
      step(2'b10, 16'h0, EXT_ZEXT, 16'h0080, EXT_SEXT8, 1'b1);
      chk("tp_sext8", res_data, 32'hFFFFFF80);
      step(2'b10, 16'h0, EXT_ZEXT, 16'h1234, EXT_LUI, 1'b1);
      chk("tp_lui", res_data, 32'h12340000);
      chk("tp_sweep_id", 32'(res_id), 32'd1);

      async_reset();
      for (int i = 0; i < 4; i++) begin
         step(2'b11, 16'h0100 + 16'(i), EXT_ZEXT, 16'h0200 + 16'(i), EXT_ZEXT, 1'b1);
         chk("tp_fair_id", 32'(res_id), 32'(i % 2));
      end

      step(2'b11, 16'h00AA, EXT_SEXT8, 16'h00BB, EXT_SEXT8, 1'b1);
      held_data = res_data;
      held_id = res_id;
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 16'h0033, EXT_LUI, 16'h0044, EXT_LUI, 1'b0);
         chk("tp_bp_data", res_data, held_data);
         chk("tp_bp_id", 32'(res_id), 32'(held_id));
      end
      step(2'b11, 16'h0033, EXT_LUI, 16'h0044, EXT_LUI, 1'b1);
      chk("tp_bp_resume_id", 32'(res_id), 32'(!held_id));

      step(2'b01, 16'h7F00, EXT_SEXT16, 16'h0, EXT_ZEXT, 1'b0);
      async_reset();
      step(2'b11, 16'h0001, EXT_ZEXT, 16'h0002, EXT_ZEXT, 1'b1);
      chk("tp_rst_tie", 32'(res_id), 32'd0);

      step(2'b01, 16'h00C3, EXT_SEXT8, 16'h0, EXT_ZEXT, 1'b1);
      step(2'b00, 16'h0, EXT_ZEXT, 16'h0, EXT_ZEXT, 1'b1);
      chk("tp_drain_valid", 32'(res_valid), 32'd0);
      chk("tp_drain_data", res_data, 32'hFFFFFFC3);

      for (int i = 0; i < 400; i++)
         step(2'($urandom), 16'($urandom), 2'($urandom), 16'($urandom), 2'($urandom),
              ($urandom_range(0, 3) != 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ext_unit_arbiter.md
Name: ext_unit_arbiter

Overview:
- Shares one immediate-extension datapath (zero/sign extend, byte sign extend, upper-immediate shift) between two requesters: decode stage (port 0) and load-alignment unit (port 1).
- Round-robin arbitration, valid/ready handshakes on both sides, one registered output stage.
- Sits between decode/LSU and the execute operand muxes.

Parameters:
- IN_W, 16, requester data width.
- OUT_W, 32, result width; must be >= 2*IN_W for LUI mode.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; handshake when valid & ready.
- req0_data  in  IN_W  requester 0 operand.
- req0_mode  in  2  requester 0 extension mode.
- req1_data  in  IN_W  requester 1 operand.
- req1_mode  in  2  requester 1 extension mode.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  OUT_W  extended result.
- res_id  out  1  requester index that owns res_data.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_data=0, res_id=0, rr_last=1 (requester 0 wins first tie). req_ready=0 while rst_n low.
- Modes:
  - 00 ZEXT: upper bits 0.
  - 01 SEXT16: replicate data[IN_W-1].
  - 10 SEXT8: use data[7:0], replicate bit 7, ignore data[IN_W-1:8].
  - 11 LUI: data << IN_W, low IN_W bits 0.
- out_free = ~res_valid | res_ready.
- Grant (combinational):
  - Only one valid: that requester.
  - Both valid: requester != rr_last.
  - None valid: no grant.
- req_ready[i] = grant[i] & out_free & rst_n. At most one ready bit high per cycle. Ready may depend on valid; requesters must not make valid depend on ready.
- On handshake:
  - Next edge loads res_data = ext(data, mode), res_id = i, res_valid = 1, rr_last = i.
  - Latency is exactly 1 cycle from accept to res_valid.
- Output:
  - res_valid & ~res_ready: res_data/res_id/res_valid held stable; no new accept.
  - res_valid & res_ready with a new handshake in the same cycle: back-to-back, one result per cycle.
  - res_valid & res_ready with no handshake: res_valid drops to 0 next edge; res_data holds its last value.
- Fairness: with both requesters continuously valid and res_ready=1, grants alternate 0,1,0,1. Neither requester waits more than one grant.
- rr_last updates only on an actual handshake, never on a mere grant under backpressure.
- Reset mid-transfer: in-flight result discarded, rr_last restored to 1, no partial handshakes.
- Invalid config (OUT_W < 2*IN_W): elaboration error via generate-time check.

Decomposition:
- Shared package ext_pkg: mode constants EXT_ZEXT=2'b00, EXT_SEXT16=2'b01, EXT_SEXT8=2'b10, EXT_LUI=2'b11; requester index constants REQ_DEC=0, REQ_LSU=1.
- One sub-module ext_core: purely combinational (data, mode) -> OUT_W result, parameterised IN_W/OUT_W.
- Arbiter, rr pointer and output register live in ext_unit_arbiter.

Test Plan:
- Reset release, req0 data=16'h0005 mode SEXT16, res_ready=1 -> next cycle res_valid=1, res_data=32'h00000005, res_id=0.
- Mode sweep on req1 with data 16'hFFFA/SEXT16, 16'h8000/ZEXT, 16'h0080/SEXT8, 16'h1234/LUI -> results 32'hFFFFFFFA, 32'h00008000, 32'hFFFFFF80, 32'h12340000, each with res_id=1, one per cycle.
- Both requesters valid for 4 cycles after reset, res_ready=1 -> res_id sequence 0,1,0,1; req_ready never 2'b11.
- Backpressure: res_ready=0 for 3 cycles with a result pending and both requesters valid -> res_data/res_id stable, req_ready=2'b00, rr_last unchanged; on res_ready=1, accept resumes with correct rr order.
- Async reset asserted mid-stream with res_valid=1 -> res_valid=0, res_data=0 immediately; after release, a tie grants requester 0 first.
- Idle drain: single result consumed with no new request -> res_valid falls next cycle, res_data retains last value.
